keccak_p400_engine: RTL and testbench
=====================================

KECCAK_P400_ENGINE -- requirements
Module: keccak_p400_engine

Interface
REQ-001 SHALL have parameter MAX_ROUNDS, default 20, the round-count clamp and index base (Keccak-p[400] nr ≤ 20).
REQ-002 SHALL provide the following ports (one clock; reset is asynchronous and active-low):
- i_common_clk  in  1  single clock shared with the state memory.
- i_rst_n  in  1  asynchronous active-low reset.
- i_v_state  in  400  permutation state read combinationally from memory port B; lane (x,y) occupies bits [16*(x+5y)+15 : 16*(x+5y)].
- i_v_ctrl_reg  in  8  control byte: bit0 start, bit1 busy, bit2 done, bits 7:3 software-owned.
- i_v_num_rounds  in  8  requested round count.
- i_a_wr_active  in  1  port A (CPU) write in progress this cycle; port A wins on collision.
- o_b_wr  out  1  port B write enable.
- o_v_state  out  400  state to write back.
- o_v_ctrl_reg  out  8  control byte to write back.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when the write-back is accepted.

Function
REQ-003 SHALL implement FSM states IDLE, CLAIM, RUN, WRBACK.
REQ-004 IDLE -> CLAIM when i_v_ctrl_reg[0]=1 and i_v_ctrl_reg[1]=0; in the same edge, SHALL latch i_v_state and nr = min(i_v_num_rounds, MAX_ROUNDS).
REQ-005 CLAIM SHALL assert o_b_wr with o_v_state = the latched state and o_v_ctrl_reg = {ctrl[7:3], done=0, busy=1, start=0}.
- The write is accepted in a cycle where i_a_wr_active=0.
- CLAIM SHALL hold o_b_wr until acceptance.
- On acceptance, SHALL go to RUN if nr>0, else to WRBACK.
REQ-006 RUN SHALL apply one full round (theta, rho, pi, chi, iota) per cycle with round index ir = MAX_ROUNDS-nr+k, for k = 0..nr-1, using 16-bit lanes and the 16 LSBs of the standard round constants.
REQ-007 RUN SHALL go to WRBACK after exactly nr cycles and SHALL not assert o_b_wr while in RUN.
REQ-008 WRBACK SHALL assert o_b_wr with o_v_state = the result and o_v_ctrl_reg = {ctrl[7:3] as latched, done=1, busy=0, start=0}.
- SHALL hold o_b_wr while i_a_wr_active=1.
- On acceptance, SHALL pulse o_done and return to IDLE.
REQ-009 Latency from start-seen edge to o_done with no collisions SHALL be nr+2 cycles; each colliding cycle SHALL add one cycle.
REQ-010 nr=0 SHALL write back the unchanged state with done=1; i_v_num_rounds > MAX_ROUNDS SHALL behave as MAX_ROUNDS.
REQ-011 Memory changes to state or control made by the CPU after IDLE SHALL be ignored and overwritten at WRBACK; start=1 seen while not in IDLE SHALL be ignored.
REQ-012 o_v_state and o_v_ctrl_reg SHALL be don't-care while o_b_wr=0; o_b_wr SHALL never be high for more than one cycle in which i_a_wr_active=0.

Reset
REQ-013 i_rst_n=0 SHALL force IDLE immediately and zero o_b_wr, o_busy, o_done, the internal state register and the round counter.
REQ-014 Reset mid-operation SHALL issue no write; the busy bit left in memory SHALL be cleared by software.

Structure
REQ-015 Package keccak_p400_pkg SHALL hold: the FSM state enum, lane width 16, MAX_ROUNDS, the 20-entry 16-bit RC table, the 25 rho offsets mod 16, and the ctrl bit positions.
REQ-016 SHALL instantiate one combinational sub-module keccak_p400_round (inputs: 400-bit state, 5-bit ir; output: 400-bit state).
REQ-017 SHALL contain one state register, one 5-bit round counter and one FSM.

Verification
REQ-018 Bench SHALL cover the following scenarios:
- All-zero state, num_rounds=1, start -> WRBACK state bits[15:0]=0x000A and all else 0; ctrl=0x04; o_done 3 cycles after the start edge.
- Random state, num_rounds=20 -> matches the golden Keccak-f[400] model; o_done at cycle 22; o_busy high throughout.
- num_rounds=0 -> written state equals input, ctrl done=1; num_rounds=25 -> identical result to num_rounds=20.
- i_a_wr_active held high 3 cycles during CLAIM and 2 cycles during WRBACK -> o_b_wr stays asserted; o_done delayed by 5 cycles; data unchanged.
- Reset asserted in the 5th RUN cycle -> o_b_wr=0 immediately; IDLE; no write; a new start after release runs correctly.
- ctrl=0x03 (start with busy set) in IDLE -> no start, no write.

Source files
------------

// File: rtl/keccak_p400_pkg.sv
// Shared definitions for the Keccak-p[400] engine.
// Holds the FSM state encoding, lane geometry, the round-count limit, the
// 16-bit round-constant table, the rho rotation offsets reduced mod 16, the
// control-byte bit positions and a lane rotate helper.
package keccak_p400_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLAIM  = 2'd1,
    ST_RUN    = 2'd2,
    ST_WRBACK = 2'd3
  } state_e;

  localparam int LANE_W     = 16;
  localparam int NUM_LANES  = 25;
  localparam int STATE_W    = LANE_W * NUM_LANES;
  localparam int MAX_ROUNDS = 20;

  // Control byte layout; bits 7:3 belong to software and are carried through.
  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;

  // Low 16 bits of the standard Keccak round constants, indexed by ir.
  localparam logic [LANE_W-1:0] RC_TAB [MAX_ROUNDS] = '{
    16'h0001, 16'h8082, 16'h808A, 16'h8000, 16'h808B,
    16'h0001, 16'h8081, 16'h8009, 16'h008A, 16'h0088,
    16'h8009, 16'h000A, 16'h808B, 16'h008B, 16'h8089,
    16'h8003, 16'h8002, 16'h0080, 16'h800A, 16'h000A
  };

  // Rho offsets mod 16, indexed by lane x+5y.
  localparam logic [3:0] RHO_OFS [NUM_LANES] = '{
    4'd0,  4'd1,  4'd14, 4'd12, 4'd11,
    4'd4,  4'd12, 4'd6,  4'd7,  4'd4,
    4'd3,  4'd10, 4'd11, 4'd9,  4'd7,
    4'd9,  4'd13, 4'd15, 4'd5,  4'd8,
    4'd2,  4'd2,  4'd13, 4'd8,  4'd14
  };

  // Rotate a lane left (toward the MSB) by n, 0 <= n < LANE_W.
  function automatic logic [LANE_W-1:0] rotl(input logic [LANE_W-1:0] v, input int n);
    logic [2*LANE_W-1:0] t;
    t = {v, v} << n;
    return t[2*LANE_W-1:LANE_W];
  endfunction

endpackage

// File: rtl/keccak_p400_round.sv
// One combinational Keccak-p[400] round: theta, rho, pi, chi, iota.
// Ports:
//   state_in  - 400-bit state, lane (x,y) at bits [16*(x+5y) +: 16]
//   ir        - round index selecting the iota constant (0..19)
//   state_out - state after the round
module keccak_p400_round
  import keccak_p400_pkg::*;
(
  input  logic [STATE_W-1:0] state_in,
  input  logic [4:0]         ir,
  output logic [STATE_W-1:0] state_out
);

  logic [NUM_LANES-1:0][LANE_W-1:0] a, b, res;
  logic [4:0][LANE_W-1:0]           c, d;
  logic [LANE_W-1:0]                rc;

  assign a  = state_in;
  assign rc = (ir < 5'(MAX_ROUNDS)) ? RC_TAB[ir] : '0;

  // theta: column parities and the per-column correction
  for (genvar x = 0; x < 5; x++) begin : g_theta
    assign c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
    assign d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
  end

  // rho + pi: lane (x,y) rotates and moves to (y, 2x+3y)
  for (genvar y = 0; y < 5; y++) begin : g_rp_y
    for (genvar x = 0; x < 5; x++) begin : g_rp_x
      assign b[y + 5*((2*x + 3*y) % 5)] = rotl(a[x+5*y] ^ d[x], int'(RHO_OFS[x+5*y]));
    end
  end

  // chi along each row, iota folded into lane (0,0)
  for (genvar y = 0; y < 5; y++) begin : g_chi_y
    for (genvar x = 0; x < 5; x++) begin : g_chi_x
      assign res[x+5*y] = b[x+5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y])
                        ^ ((x + 5*y == 0) ? rc : '0);
    end
  end

  assign state_out = res;

endmodule

// File: rtl/keccak_p400_engine.sv
// Keccak-p[400] permutation engine sharing a dual-port state memory with a CPU.
// On start (ctrl bit0 set, busy clear) it latches the state, claims the block
// by writing busy back, runs nr rounds at one per cycle, then writes the
// result with done set. The CPU port wins every write collision.
// Ports:
//   i_common_clk, i_rst_n - clock, async active-low reset
//   i_v_state, i_v_ctrl_reg, i_v_num_rounds - memory port B read data
//   i_a_wr_active - CPU write this cycle; blocks our write
//   o_b_wr, o_v_state, o_v_ctrl_reg - memory port B write
//   o_busy - not idle; o_done - one-cycle pulse after result accepted
module keccak_p400_engine
  import keccak_p400_pkg::*;
#(
  parameter int MAX_ROUNDS = keccak_p400_pkg::MAX_ROUNDS
) (
  input  logic               i_common_clk,
  input  logic               i_rst_n,
  input  logic [STATE_W-1:0] i_v_state,
  input  logic [7:0]         i_v_ctrl_reg,
  input  logic [7:0]         i_v_num_rounds,
  input  logic               i_a_wr_active,
  output logic               o_b_wr,
  output logic [STATE_W-1:0] o_v_state,
  output logic [7:0]         o_v_ctrl_reg,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [4:0] IR_END = 5'(MAX_ROUNDS);

  state_e             state_q, state_d;
  logic [STATE_W-1:0] st_q, round_out;
  logic [4:0]         ir_q;      // current round index; starts at MAX_ROUNDS-nr
  logic [4:0]         nr_clamp;
  logic [7:3]         sw_q;
  logic               done_q;
  logic               start_ok;
  logic               unused_ctrl;

  assign unused_ctrl = i_v_ctrl_reg[CTRL_DONE];
  assign start_ok    = i_v_ctrl_reg[CTRL_START] && !i_v_ctrl_reg[CTRL_BUSY];
  assign nr_clamp    = (i_v_num_rounds > 8'(MAX_ROUNDS)) ? IR_END : i_v_num_rounds[4:0];

  keccak_p400_round u_round (
    .state_in  (st_q),
    .ir        (ir_q),
    .state_out (round_out)
  );

  always_ff @(posedge i_common_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    o_b_wr       = 1'b0;
    o_busy       = 1'b1;
    o_v_ctrl_reg = {sw_q, 3'b000};
    case (state_q)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (start_ok) state_d = ST_CLAIM;
      end
      ST_CLAIM: begin
        o_b_wr                  = 1'b1;
        o_v_ctrl_reg[CTRL_BUSY] = 1'b1;
        // ir already equal to the end index means zero rounds requested
        if (!i_a_wr_active) state_d = (ir_q == IR_END) ? ST_WRBACK : ST_RUN;
      end
      ST_RUN: begin
        if (ir_q == IR_END - 5'd1) state_d = ST_WRBACK;
      end
      ST_WRBACK: begin
        o_b_wr                  = 1'b1;
        o_v_ctrl_reg[CTRL_DONE] = 1'b1;
        if (!i_a_wr_active) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_common_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q   <= '0;
      ir_q   <= '0;
      sw_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == ST_WRBACK) && !i_a_wr_active;
      case (state_q)
        ST_IDLE: if (start_ok) begin
          st_q <= i_v_state;
          ir_q <= IR_END - nr_clamp;
          sw_q <= i_v_ctrl_reg[7:3];
        end
        ST_RUN: begin
          st_q <= round_out;
          ir_q <= ir_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_v_state = st_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_keccak_p400_engine.sv
module tb_keccak_p400_engine;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [399:0] mem_st = '0, cpu_st = '0, o_st;
  logic [7:0]   mem_ctrl = '0, cpu_ctrl = '0, num_rounds = '0, o_ctrl;
  logic         cpu_wr = 1'b0, b_wr, busy, done;

  keccak_p400_engine dut (
    .i_common_clk   (clk),
    .i_rst_n        (rst_n),
    .i_v_state      (mem_st),
    .i_v_ctrl_reg   (mem_ctrl),
    .i_v_num_rounds (num_rounds),
    .i_a_wr_active  (cpu_wr),
    .o_b_wr         (b_wr),
    .o_v_state      (o_st),
    .o_v_ctrl_reg   (o_ctrl),
    .o_busy         (busy),
    .o_done         (done)
  );

  // Dual-port memory: CPU port A wins over engine port B.
  always @(posedge clk) begin
    if (cpu_wr) begin
      mem_st <= cpu_st; mem_ctrl <= cpu_ctrl;
    end else if (b_wr) begin
      mem_st <= o_st; mem_ctrl <= o_ctrl;
    end
  end

  typedef struct { logic [399:0] st; logic [7:0] ctrl; } wr_t;
  wr_t exp_q[$];
  int n_checks = 0, n_fail = 0, n_writes = 0, exp_writes = 0;

  task automatic chk(input string name, input logic [399:0] got, input logic [399:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every accepted port-B write is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && b_wr && !cpu_wr) begin
      wr_t e;
      n_writes++;
      if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("wr_state", o_st, e.st);
        chk("wr_ctrl", {392'h0, o_ctrl}, {392'h0, e.ctrl});
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] rot16(input logic [15:0] v, input int n);
    int k;
    k = n % 16;
    if (k == 0) return v;
    return (v << k) | (v >> (16 - k));
  endfunction

  function automatic logic rc_bit(input int t);
    logic [8:0] r9;
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i <= t % 255; i++) begin
      r9 = {r, 1'b0};
      r9[0] = r9[0] ^ r9[8]; r9[4] = r9[4] ^ r9[8];
      r9[5] = r9[5] ^ r9[8]; r9[6] = r9[6] ^ r9[8];
      r = r9[7:0];
    end
    return r[0];
  endfunction

  function automatic logic [399:0] kmodel(input logic [399:0] s, input int nr);
    logic [15:0] A [5][5], B [5][5], C [5], D [5];
    int ro [5][5];
    int x, y, tx;
    logic [399:0] out;
    for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) A[i][j] = s[16*(i+5*j) +: 16];
    ro[0][0] = 0; x = 1; y = 0;
    for (int t = 0; t < 24; t++) begin
      ro[x][y] = ((t+1)*(t+2)/2) % 16;
      tx = x; x = y; y = (2*tx + 3*y) % 5;
    end
    for (int ir = 20 - nr; ir < 20; ir++) begin
      for (int i = 0; i < 5; i++) C[i] = A[i][0] ^ A[i][1] ^ A[i][2] ^ A[i][3] ^ A[i][4];
      for (int i = 0; i < 5; i++) D[i] = C[(i+4)%5] ^ rot16(C[(i+1)%5], 1);
      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++)
        B[j][(2*i+3*j)%5] = rot16(A[i][j] ^ D[i], ro[i][j]);
      for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++)
        A[i][j] = B[i][j] ^ (~B[(i+1)%5][j] & B[(i+2)%5][j]);
      for (int j = 0; j < 5; j++)
        if (rc_bit(j + 7*ir)) A[0][0] = A[0][0] ^ (16'h1 << ((1 << j) - 1));
    end
    for (int i = 0; i < 5; i++) for (int j = 0; j < 5; j++) out[16*(i+5*j) +: 16] = A[i][j];
    return out;
  endfunction

  function automatic logic [399:0] mkpat(input int seed);
    logic [31:0] v;
    logic [399:0] p;
    v = 32'(seed) * 32'h9E3779B9 + 32'h1234567;
    for (int i = 0; i < 25; i++) begin
      v = v * 32'd1103515245 + 32'd12345;
      p[16*i +: 16] = v[31:16];
    end
    return p;
  endfunction

  // ---------------- stimulus ----------------
  task automatic cpu_write(input logic [399:0] s, input logic [7:0] c);
    @(posedge clk); #1;
    cpu_st = s; cpu_ctrl = c; cpu_wr = 1'b1;
    @(posedge clk); #1;
    cpu_wr = 1'b0;
  endtask

  task automatic run_job(input logic [399:0] s, input logic [4:0] sw, input int nr_in,
                         input int cc, input int cw, input logic [399:0] exp_res);
    wr_t e;
    int nre, cnt, lat;
    logic busy_ok;
    nre = (nr_in > 20) ? 20 : nr_in;
    lat = nre + 2 + cc + cw;
    e.st = s;       e.ctrl = {sw, 3'b010}; exp_q.push_back(e);
    e.st = exp_res; e.ctrl = {sw, 3'b100}; exp_q.push_back(e);
    exp_writes += 2;
    num_rounds = 8'(nr_in);
    cpu_write(s, {sw, 3'b001});
    @(posedge clk); #1;           // engine sees start on this edge
    cnt = 0; busy_ok = 1'b1;
    while (!done && cnt < 200) begin
      if (!busy) busy_ok = 1'b0;
      cpu_wr = 1'b0;
      if (b_wr && o_ctrl[1] && cc > 0) begin
        cpu_wr = 1'b1; cpu_st = ~s; cpu_ctrl = 8'h01; cc--;
      end else if (b_wr && o_ctrl[2] && cw > 0) begin
        cpu_wr = 1'b1; cpu_st = ~s; cpu_ctrl = 8'h01; cw--;
      end
      @(posedge clk); #1;
      cnt++;
    end
    cpu_wr = 1'b0;
    chk("done_latency", cnt, lat);
    chk("busy_throughout", busy_ok, 1);
    chk("busy_low_at_done", busy, 0);
    chk("mem_state", mem_st, exp_res);
    chk("mem_ctrl", {392'h0, mem_ctrl}, {392'h0, sw, 3'b100});
    @(posedge clk); #1;
    chk("done_pulse_end", done, 0);
  endtask

  task automatic reset_mid(input logic [399:0] s, input logic [4:0] sw);
    wr_t e;
    e.st = s; e.ctrl = {sw, 3'b010}; exp_q.push_back(e);
    exp_writes += 1;
    num_rounds = 8'd20;
    cpu_write(s, {sw, 3'b001});
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end   // inside the 5th RUN cycle
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_b_wr", b_wr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 0);
    chk("post_rst_mem_ctrl", {392'h0, mem_ctrl}, {392'h0, sw, 3'b010});
    chk("post_rst_mem_state", mem_st, s);
    cpu_write(s, 8'h00);           // software clears the stale busy bit
  endtask

  task automatic no_start(input logic [399:0] s);
    logic quiet;
    quiet = 1'b1;
    cpu_write(s, 8'h03);
    repeat (8) begin
      @(posedge clk); #1;
      if (busy || b_wr) quiet = 1'b0;
    end
    chk("busy_set_no_start", quiet, 1);
    chk("busy_set_mem_ctrl", {392'h0, mem_ctrl}, {392'h0, 8'h03});
  endtask

  initial begin
    logic [399:0] p1, p2, p3;
    p1 = mkpat(1); p2 = mkpat(2); p3 = mkpat(3);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_b_wr", b_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    run_job('0, 5'h00, 1, 0, 0, {384'h0, 16'h000A});
    run_job(p1, 5'h15, 20, 0, 0, kmodel(p1, 20));
    run_job(p2, 5'h0A, 0, 0, 0, p2);
    run_job(p1, 5'h1F, 25, 0, 0, kmodel(p1, 20));
    run_job(p3, 5'h03, 4, 3, 2, kmodel(p3, 4));
    reset_mid(p3, 5'h11);
    run_job(p2, 5'h06, 3, 0, 0, kmodel(p2, 3));
    no_start(p1);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("write_count", n_writes, exp_writes);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
